// File: rtl/io_port_unit.sv
// cin/cout I/O unit: RX and TX byte FIFOs with word assembly/splitting and
// hazard-unit stall generation for the 5-stage core.
module io_port_unit #(
  parameter int RX_DEPTH = 16,
  parameter int TX_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_req,
  input  logic        in_word,
  output logic [31:0] in_data,
  output logic        in_stall,
  input  logic        out_req,
  input  logic        out_word,
  input  logic [31:0] out_data,
  output logic        out_stall,
  input  logic        cache_stall,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_overrun,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int RX_CW = RX_AW + 1;
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int TX_CW = TX_AW + 1;

  logic [7:0]       rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] rx_rd_ptr, rx_wr_ptr;
  logic [RX_CW-1:0] rx_count, in_n, rx_pops;
  logic             in_fire, rx_accept;
  logic [7:0]       rx_byte [4];

  logic [7:0]       tx_mem [TX_DEPTH];
  logic [TX_AW-1:0] tx_rd_ptr, tx_wr_ptr;
  logic [TX_CW-1:0] tx_count, out_n, tx_pushes;
  logic             out_fire, tx_pop;

  // RX side: stall ignores cache_stall so the hazard unit sees no loop
  always_comb begin
    in_n      = in_word ? RX_CW'(4) : RX_CW'(1);
    in_stall  = in_req && (rx_count < in_n);
    in_fire   = in_req && !in_stall && !cache_stall;
    rx_pops   = in_fire ? in_n : '0;
    rx_accept = rx_valid && ((rx_count - rx_pops) < RX_CW'(RX_DEPTH));
    for (int k = 0; k < 4; k++) begin
      rx_byte[k] = rx_mem[rx_rd_ptr + RX_AW'(k)];
    end
  end

  // TX side: capacity is judged before this cycle's drain pop
  always_comb begin
    out_n     = out_word ? TX_CW'(4) : TX_CW'(1);
    out_stall = out_req && ((TX_CW'(TX_DEPTH) - tx_count) < out_n);
    out_fire  = out_req && !out_stall && !cache_stall;
    tx_pushes = out_fire ? out_n : '0;
    tx_valid  = (tx_count != '0);
    tx_pop    = tx_valid && tx_ready;
    tx_data   = tx_mem[tx_rd_ptr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_rd_ptr  <= '0;
      rx_wr_ptr  <= '0;
      rx_count   <= '0;
      rx_overrun <= 1'b0;
      in_data    <= '0;
      tx_rd_ptr  <= '0;
      tx_wr_ptr  <= '0;
      tx_count   <= '0;
    end else begin
      if (rx_accept) rx_wr_ptr <= rx_wr_ptr + RX_AW'(1);
      rx_rd_ptr <= rx_rd_ptr + rx_pops[RX_AW-1:0];
      rx_count  <= rx_count + RX_CW'(rx_accept) - rx_pops;
      if (rx_valid && !rx_accept) rx_overrun <= 1'b1;
      if (in_fire) begin
        in_data <= in_word ? {rx_byte[3], rx_byte[2], rx_byte[1], rx_byte[0]}
                           : {24'b0, rx_byte[0]};
      end
      if (tx_pop) tx_rd_ptr <= tx_rd_ptr + TX_AW'(1);
      tx_wr_ptr <= tx_wr_ptr + tx_pushes[TX_AW-1:0];
      tx_count  <= tx_count + tx_pushes - TX_CW'(tx_pop);
    end
  end

  // FIFO storage is data only; validity is carried by the counters
  always_ff @(posedge clk) begin
    if (rx_accept) rx_mem[rx_wr_ptr] <= rx_data;
    if (out_fire) begin
      tx_mem[tx_wr_ptr] <= out_data[7:0];
      if (out_word) begin
        tx_mem[tx_wr_ptr + TX_AW'(1)] <= out_data[15:8];
        tx_mem[tx_wr_ptr + TX_AW'(2)] <= out_data[23:16];
        tx_mem[tx_wr_ptr + TX_AW'(3)] <= out_data[31:24];
      end
    end
  end

endmodule

// File: tb/tb_io_port_unit.sv
// Self-checking bench for io_port_unit: directed scenarios plus random
// traffic against a queue-based reference model.
module tb_io_port_unit;
  localparam int RX_DEPTH = 16;
  localparam int TX_DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_req, in_word, in_stall;
  logic [31:0] in_data;
  logic        out_req, out_word, out_stall;
  logic [31:0] out_data;
  logic        cache_stall;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_overrun;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  io_port_unit #(.RX_DEPTH(RX_DEPTH), .TX_DEPTH(TX_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_req(in_req), .in_word(in_word), .in_data(in_data), .in_stall(in_stall),
    .out_req(out_req), .out_word(out_word), .out_data(out_data), .out_stall(out_stall),
    .cache_stall(cache_stall),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_overrun(rx_overrun),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic [7:0]  rxq[$];
  logic [7:0]  txq[$];
  logic [31:0] exp_in_data = '0;
  logic        exp_ovr = 1'b0;
  bit          exp_is, exp_os;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check against model, advance model, clock.
  task automatic step(input bit ir, input bit iw, input bit orq, input bit ow,
                      input logic [31:0] od, input bit cs, input bit rv,
                      input logic [7:0] rd, input bit tr);
    int n_in, n_out;
    bit fire_in, fire_out, pop_tx;
    in_req = ir; in_word = iw; out_req = orq; out_word = ow; out_data = od;
    cache_stall = cs; rx_valid = rv; rx_data = rd; tx_ready = tr;
    #1;
    n_in     = iw ? 4 : 1;
    n_out    = ow ? 4 : 1;
    exp_is   = ir && (rxq.size() < n_in);
    exp_os   = orq && ((TX_DEPTH - txq.size()) < n_out);
    fire_in  = ir && !exp_is && !cs;
    fire_out = orq && !exp_os && !cs;
    pop_tx   = (txq.size() > 0) && tr;
    check("in_stall", 32'(in_stall), 32'(exp_is));
    check("out_stall", 32'(out_stall), 32'(exp_os));
    check("tx_valid", 32'(tx_valid), 32'(txq.size() > 0));
    if (txq.size() > 0) check("tx_data", 32'(tx_data), 32'(txq[0]));
    check("in_data", in_data, exp_in_data);
    check("rx_overrun", 32'(rx_overrun), 32'(exp_ovr));
    if (fire_in) begin
      exp_in_data = '0;
      for (int k = 0; k < n_in; k++) exp_in_data[8*k +: 8] = rxq.pop_front();
    end
    if (rv) begin
      if (rxq.size() < RX_DEPTH) rxq.push_back(rd);
      else exp_ovr = 1'b1;
    end
    if (pop_tx) void'(txq.pop_front());
    if (fire_out) for (int k = 0; k < n_out; k++) txq.push_back(od[8*k +: 8]);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit tr);
    step(0, 0, 0, 0, 32'h0, 0, 0, 8'h0, tr);
  endtask

  bit          hir, hiw, hor, how;
  logic [31:0] hod;

  initial begin
    rst = 1'b1;
    in_req = 0; in_word = 0; out_req = 0; out_word = 0; out_data = '0;
    cache_stall = 0; rx_valid = 0; rx_data = '0; tx_ready = 0;
    #2;
    check("rst_in_stall", 32'(in_stall), 32'h0);
    check("rst_out_stall", 32'(out_stall), 32'h0);
    check("rst_tx_valid", 32'(tx_valid), 32'h0);
    check("rst_in_data", in_data, 32'h0);
    check("rst_overrun", 32'(rx_overrun), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(0);

    // word read: three bytes stall, fourth releases
    step(0, 0, 0, 0, 0, 0, 1, 8'h11, 0);
    step(0, 0, 0, 0, 0, 0, 1, 8'h22, 0);
    step(1, 1, 0, 0, 0, 0, 1, 8'h33, 0);
    check("word_stall3", 32'(in_stall), 32'h1);
    step(1, 1, 0, 0, 0, 0, 1, 8'h44, 0);
    step(1, 1, 0, 0, 0, 0, 0, 8'h0, 0);
    idle(0);
    check("word_data", in_data, 32'h44332211);
    check("word_empty_stall", 32'(exp_is), 32'h0);

    // byte read held by cache_stall pops once
    step(0, 0, 0, 0, 0, 0, 1, 8'hA5, 0);
    repeat (3) step(1, 0, 0, 0, 0, 1, 0, 8'h0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 8'h0, 0);
    step(1, 0, 0, 0, 0, 1, 0, 8'h0, 0);
    check("byte_data", in_data, 32'h000000A5);
    check("byte_one_pop", 32'(in_stall), 32'h1);
    idle(0);

    // word write and drain, LSB first
    step(0, 0, 1, 1, 32'hDEADBEEF, 0, 0, 8'h0, 1);
    check("drain_b0", 32'(tx_data), 32'hEF);
    idle(1);
    check("drain_b1", 32'(tx_data), 32'hBE);
    idle(1);
    check("drain_b2", 32'(tx_data), 32'hAD);
    idle(1);
    check("drain_b3", 32'(tx_data), 32'hDE);
    idle(1);
    check("drain_done", 32'(tx_valid), 32'h0);

    // TX full: fifth word waits for four drained bytes
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 32'h01020304 * (i + 1), 0, 0, 8'h0, 0);
    step(0, 0, 1, 1, 32'hCAFEF00D, 0, 0, 8'h0, 0);
    check("txfull_stall", 32'(out_stall), 32'h1);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 1, 32'hCAFEF00D, 0, 0, 8'h0, 1);
    check("txfull_released", 32'(exp_os), 32'h0);
    repeat (20) idle(1);

    // RX overrun: 17th byte dropped, order intact
    for (int i = 1; i <= 17; i++) step(0, 0, 0, 0, 0, 0, 1, 8'(i), 0);
    check("overrun_set", 32'(rx_overrun), 32'h1);
    step(1, 0, 0, 0, 0, 0, 0, 8'h0, 0);
    idle(0);
    check("overrun_byte1", in_data, 32'h1);
    check("overrun_sticky", 32'(rx_overrun), 32'h1);

    // wrap-around: full FIFO, word pop and push in the same cycle
    step(0, 0, 0, 0, 0, 0, 1, 8'h18, 0);
    step(1, 1, 0, 0, 0, 0, 1, 8'h19, 0);
    idle(0);
    check("wrap_word", in_data, 32'h05040302);
    check("wrap_count13", 32'(rxq.size()), 32'd13);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0, 0, 8'h0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 8'h0, 0);
    idle(0);
    check("wrap_last", in_data, 32'h19);

    // asynchronous reset mid-operation
    step(0, 0, 1, 1, 32'h55667788, 0, 1, 8'h77, 0);
    step(1, 0, 0, 0, 0, 1, 0, 8'h0, 0);
    rst = 1'b1;
    #1;
    check("async_tx_valid", 32'(tx_valid), 32'h0);
    check("async_in_stall", 32'(in_stall), 32'h1);
    check("async_in_data", in_data, 32'h0);
    check("async_overrun", 32'(rx_overrun), 32'h0);
    rxq.delete(); txq.delete(); exp_in_data = '0; exp_ovr = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(0);

    // random traffic; requests stay stable while stalled
    hir = 0; hiw = 0; hor = 0; how = 0; hod = '0;
    for (int c = 0; c < 3000; c++) begin
      if (!(hir && exp_is)) begin
        hir = ($urandom_range(0, 2) == 0);
        hiw = $urandom_range(0, 1);
      end
      if (!(hor && exp_os)) begin
        hor = ($urandom_range(0, 2) == 0);
        how = $urandom_range(0, 1);
        hod = $urandom;
      end
      step(hir, hiw, hor, how, hod, ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 1) == 1), 8'($urandom), ($urandom_range(0, 2) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
